// File: rtl/mul_scheduler.sv
// Round-robin scheduler sharing one iterative repeated-addition multiplier among
// NREQ requesters, with a single registered valid/ready response port.
module mul_scheduler #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_product,
  output logic                  rsp_ovf,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_cnt;
  logic [IDW-1:0]   r_id;
  logic             r_ovf;
  logic [IDW-1:0]   r_ptr;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_product;
  logic             r_rsp_ovf;
  logic [IDW-1:0]   r_rsp_id;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW:0]     w_scan;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_grant;

  // Scan ptr, ptr+1, ... (mod NREQ); the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_scan >= (IDW+1)'(NREQ)) w_scan = w_scan - (IDW+1)'(NREQ);
      if (!w_found && req_valid[w_scan[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_win == IDW'(k)) begin
        w_a = req_a[k*WIDTH +: WIDTH];
        w_b = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt        = (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);
  assign {w_carry, w_sum} = {1'b0, r_p} + {1'b0, r_a};
  assign w_grant          = (r_state == IDLE) && w_found;

  // Gated by rst_n so no requester sees an accept strobe while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && w_grant) req_ready[w_win] = 1'b1;
  end

  // DONE spends its first cycle loading the response registers, then holds them
  // until the consumer handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_a           <= '0;
      r_p           <= '0;
      r_cnt         <= '0;
      r_id          <= '0;
      r_ovf         <= 1'b0;
      r_ptr         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_product <= '0;
      r_rsp_ovf     <= 1'b0;
      r_rsp_id      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a     <= w_a;
            r_cnt   <= w_b;
            r_p     <= '0;
            r_ovf   <= 1'b0;
            r_id    <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_state <= ACC;
          end
        end
        ACC: begin
          if (r_cnt != '0) begin
            r_p   <= w_sum;
            r_ovf <= r_ovf | w_carry;
            r_cnt <= r_cnt - WIDTH'(1);
          end else begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!r_rsp_valid) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_product <= r_p;
            r_rsp_ovf     <= r_ovf;
            r_rsp_id      <= r_id;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_product = r_rsp_product;
  assign rsp_ovf     = r_rsp_ovf;
  assign rsp_id      = r_rsp_id;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler: expected responses are queued when a job is
// issued and checked in order as the DUT hands them over.
module tb_mul_scheduler;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [WIDTH-1:0]      rsp_product;
  logic                  rsp_ovf;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic             ovf;
    logic [IDW-1:0]   id;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  mul_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_product(rsp_product),
    .rsp_ovf    (rsp_ovf),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id, input int a, input int b);
    exp_t        e;
    int unsigned prod;
    prod  = int'(a) * int'(b);
    e.p   = prod[WIDTH-1:0];
    e.ovf = (prod >= 32'd65536);
    e.id  = IDW'(id);
    q.push_back(e);
  endtask

  task automatic issue(input int id, input int a, input int b);
    logic [31:0] av, bv;
    av = a;
    bv = b;
    req_a[id*WIDTH +: WIDTH] = av[WIDTH-1:0];
    req_b[id*WIDTH +: WIDTH] = bv[WIDTH-1:0];
    req_valid[id] = 1'b1;
    push_exp(id, a, b);
  endtask

  task automatic wait_accept(input int id);
    int n = 0;
    @(negedge clk);
    while (!req_ready[id] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("grant_wait", req_ready[id], 1);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic measure(input int exp_lat);
    int n       = 0;
    bit busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      busy_ok &= busy;
    end while (!rsp_valid && n < 400);
    check("latency", n, exp_lat);
    check("busy_during_job", busy_ok, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain", q.size(), 0);
    #1;
    check("valid_after_hs", rsp_valid, 0);
    check("busy_after_hs", busy, 0);
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_valid"}, rsp_valid, 0);
    check({tag, "_product"}, rsp_product, 0);
    check({tag, "_ovf"}, rsp_ovf, 0);
    check({tag, "_id"}, rsp_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, req_ready, 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    reset_outputs_zero("rst");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: one pop per handshake, plus one-hot accept check.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_onehot0", $onehot0(req_ready), 1);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("rsp_product", rsp_product, mon_e.p);
          check("rsp_ovf", rsp_ovf, mon_e.ovf);
          check("rsp_id", rsp_id, mon_e.id);
        end
      end
    end
  end

  initial begin
    logic [NREQ-1:0] expv;
    bit              ok;
    int              n;

    // Reset state, then single job
    do_reset();
    rsp_ready = 1'b1;
    issue(0, 7, 5);
    wait_accept(0);
    measure(7);
    drain();

    // Zero multiplier
    issue(2, 1234, 0);
    wait_accept(2);
    measure(2);
    drain();

    // Overflow
    issue(1, 300, 300);
    wait_accept(1);
    measure(302);
    drain();

    // Round robin with every requester held valid from reset
    do_reset();
    for (int i = 0; i < 4; i++) issue(i, i + 1, 3);
    push_exp(0, 1, 3);
    for (int g = 0; g < 5; g++) begin
      expv = '0;
      expv[g % 4] = 1'b1;
      n = 0;
      @(negedge clk);
      while (req_ready == '0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("rr_grant", req_ready, expv);
      @(posedge clk);
      #1;
      if (g == 4) req_valid = '0;
    end
    drain();

    // Backpressure: response held while another requester waits
    rsp_ready = 1'b0;
    issue(3, 9, 4);
    wait_accept(3);
    measure(6);
    issue(1, 2, 2);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      ok &= rsp_valid && (rsp_product == 16'd36) && (rsp_id == 2'd3) && (req_ready == '0);
    end
    check("bp_hold_stable", ok, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", rsp_valid, 0);
    wait_accept(1);
    drain();

    // Asynchronous reset in the middle of accumulation
    issue(2, 5, 100);
    wait_accept(2);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    reset_outputs_zero("midrst");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      ok &= !rsp_valid && !busy;
    end
    check("no_rsp_after_abort", ok, 1);

    // Pointer must restart at 0: req 1 beats req 3
    issue(1, 6, 7);
    issue(3, 11, 2);
    @(negedge clk);
    check("ptr_restart", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    measure(9);
    wait_accept(3);
    drain();

    repeat (30) @(posedge clk);
    check("final_queue", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
